// File: rtl/pool_mem_write_ctrl_pkg.sv
// Shared types and helpers for the pooling-layer output write controller.
package pool_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    // Width needed to hold the values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_mem_write_ctrl_if.sv
// Handshake/bus bundle between a pooling unit and the output write controller.
// The optional base_addr input exists only when POOL_WR_BASE_EN is defined.
interface pool_mem_write_ctrl_if
    import pool_mem_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int ADDR_W   = 4
) ();

    localparam int CH_W = clog2_min1(CHANNELS);

    logic                start;
    logic                enable;
`ifdef POOL_WR_BASE_EN
    logic [ADDR_W-1:0]   base_addr;
`endif
    logic [CHANNELS-1:0] wr_en;
    logic [ADDR_W-1:0]   addr;
    logic [CH_W-1:0]     ch;
    logic                busy;
    logic                done;

    // Pooling unit / sequencer side.
    modport master (
        output start,
        output enable,
`ifdef POOL_WR_BASE_EN
        output base_addr,
`endif
        input  wr_en,
        input  addr,
        input  ch,
        input  busy,
        input  done
    );

    // Write controller side.
    modport slave (
        input  start,
        input  enable,
`ifdef POOL_WR_BASE_EN
        input  base_addr,
`endif
        output wr_en,
        output addr,
        output ch,
        output busy,
        output done
    );

endinterface

// File: rtl/pool_mem_write_ctrl_wrap_counter.sv
// Modulo-N counter with synchronous clear and a terminal-count flag.
module wrap_counter
    import pool_mem_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       inc,
    output logic [clog2_min1(N)-1:0]   cnt,
    output logic                       last
);

    localparam int W = clog2_min1(N);

    assign last = (cnt == W'(N - 1));

    // Count 0..N-1 on each inc, wrapping after N-1; clr restarts at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/pool_mem_write_ctrl.sv
// Write-address generator for pooling-layer output RAMs: one write per
// enabled cycle, channel innermost, then column, then row.
// Optional feature macro: POOL_WR_BASE_EN adds a base address latched on start.
module pool_mem_write_ctrl
    import pool_mem_pkg::*;
#(
    parameter int IMG_W    = 4,
    parameter int IMG_H    = 4,
    parameter int CHANNELS = 1,
    parameter int ADDR_W   = clog2_min1(IMG_W * IMG_H)
) (
    input  logic                  clk,
    input  logic                  reset,
    pool_mem_write_ctrl_if.slave  bus
);

    localparam int CH_W  = clog2_min1(CHANNELS);
    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);

    wr_state_t         state_q;
    wr_state_t         state_d;
    logic              accept;
    logic              fire;
    logic              terminal;
    logic              ch_last;
    logic              col_last;
    logic              row_last;
    logic [CH_W-1:0]   ch_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] start_base;
    logic [ADDR_W-1:0] wrap_base;
    logic              unused_cnt_bits;

    // A start is only honoured outside a pass; a write only happens inside one.
    assign accept   = bus.start && (state_q != WRITE);
    assign fire     = bus.enable && (state_q == WRITE);
    assign terminal = fire && ch_last && col_last && row_last;

    // Column/row positions are tracked only for their terminal flags; the
    // address runs as its own incrementer so no multiply is needed.
    assign unused_cnt_bits = ^{col_cnt, row_cnt};

`ifdef POOL_WR_BASE_EN
    logic [ADDR_W-1:0] base_q;

    assign start_base = bus.base_addr;
    assign wrap_base  = base_q;

    // Hold the base offset of the current map for the whole pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
        end else if (accept) begin
            base_q <= bus.base_addr;
        end
    end
`else
    assign start_base = '0;
    assign wrap_base  = '0;
`endif

    wrap_counter #(.N(CHANNELS)) u_ch_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (fire),
        .cnt   (ch_cnt),
        .last  (ch_last)
    );

    wrap_counter #(.N(IMG_W)) u_col_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (fire && ch_last),
        .cnt   (col_cnt),
        .last  (col_last)
    );

    wrap_counter #(.N(IMG_H)) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (fire && ch_last && col_last),
        .cnt   (row_cnt),
        .last  (row_last)
    );

    // Pixel address steps once per pixel (after the last channel) and
    // returns to the base when the final pixel of the map retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= start_base;
        end else if (fire && ch_last) begin
            addr_q <= terminal ? wrap_base : addr_q + ADDR_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start opens a pass, the terminal write closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = WRITE;
            WRITE:   if (terminal)  state_d = DONE;
            DONE:    if (bus.start) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    // One-hot write strobe to the channel RAM selected this cycle.
    always_comb begin
        bus.wr_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.wr_en[i] = fire && (ch_cnt == CH_W'(i));
        end
    end

    assign bus.addr = addr_q;
    assign bus.ch   = ch_cnt;
    assign bus.busy = (state_q == WRITE);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_pool_mem_write_ctrl.sv
// Randomised bench for pool_mem_write_ctrl: two instances (4x4x1 and 3x2x2)
// driven in lockstep and compared every cycle against a write-index model.
// With POOL_WR_BASE_EN defined the 4x4x1 instance uses a 6-bit address.
module tb_pool_mem_write_ctrl;
    import pool_mem_pkg::*;

`ifdef POOL_WR_BASE_EN
    localparam int A_AW    = 6;
    localparam int A_BASE0 = 32;
`else
    localparam int A_AW    = 4;
    localparam int A_BASE0 = 0;
`endif
    localparam int B_AW = 3;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic enable;
    logic [A_AW-1:0] base_a;
    logic [B_AW-1:0] base_b;

    int checks   = 0;
    int failures = 0;

    int mw[2]  = '{4, 3};
    int mh[2]  = '{4, 2};
    int mc[2]  = '{1, 2};
    int maw[2] = '{A_AW, B_AW};

    int m_phase[2] = '{0, 0};
    int m_k[2]     = '{0, 0};
    int m_base[2]  = '{0, 0};
    int wr_cnt[2]  = '{0, 0};
    int pass_no[2] = '{0, 0};
    int seq_addr[2][16];
    int seq_wr[2][16];

    int act_wr[2];
    int act_addr[2];
    int act_ch[2];
    int act_busy[2];
    int act_done[2];

    int b_addr_lit[12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
    int b_wr_lit[12]   = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
    int pass_len[2]    = '{16, 12};

    always #5 clk = ~clk;

    pool_mem_write_ctrl_if #(.CHANNELS(1), .ADDR_W(A_AW)) bus_a ();
    pool_mem_write_ctrl_if #(.CHANNELS(2), .ADDR_W(B_AW)) bus_b ();

    assign bus_a.start  = start;
    assign bus_a.enable = enable;
    assign bus_b.start  = start;
    assign bus_b.enable = enable;
`ifdef POOL_WR_BASE_EN
    assign bus_a.base_addr = base_a;
    assign bus_b.base_addr = base_b;
`endif

    pool_mem_write_ctrl #(.IMG_W(4), .IMG_H(4), .CHANNELS(1), .ADDR_W(A_AW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pool_mem_write_ctrl #(.IMG_W(3), .IMG_H(2), .CHANNELS(2), .ADDR_W(B_AW)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow from the write index k of the current pass.
    task automatic checkOutput(input int id);
        int modv;
        int e_wr;
        int e_addr;
        int e_ch;
        int e_busy;
        int e_done;
        string p;
        modv = 1 << maw[id];
        p = (id == 0) ? "a" : "b";
        e_wr = 0; e_addr = 0; e_ch = 0; e_busy = 0; e_done = 0;
        if (!reset) begin
            if (m_phase[id] == 1) begin
                e_wr   = enable ? (1 << (m_k[id] % mc[id])) : 0;
                e_addr = (m_base[id] + m_k[id] / mc[id]) % modv;
                e_ch   = m_k[id] % mc[id];
                e_busy = 1;
            end else if (m_phase[id] == 2) begin
                e_addr = m_base[id] % modv;
                e_done = 1;
            end
        end
        cmp({p, ".wr_en"}, act_wr[id],   e_wr);
        cmp({p, ".addr"},  act_addr[id], e_addr);
        cmp({p, ".ch"},    act_ch[id],   e_ch);
        cmp({p, ".busy"},  act_busy[id], e_busy);
        cmp({p, ".done"},  act_done[id], e_done);
    endtask

    // Pin each finished pass with hand-derived literals.
    task automatic checkPass(input int id);
        string p;
        p = (id == 0) ? "a" : "b";
        cmp({p, ".writes_per_pass"}, wr_cnt[id], pass_len[id]);
        if (pass_no[id] == 0) begin
            for (int i = 0; i < pass_len[id]; i++) begin
                if (id == 0) begin
                    cmp($sformatf("a.first_pass_addr[%0d]", i), seq_addr[0][i], A_BASE0 + i);
                    cmp($sformatf("a.first_pass_wr[%0d]", i),   seq_wr[0][i],   1);
                end else begin
                    cmp($sformatf("b.first_pass_addr[%0d]", i), seq_addr[1][i], b_addr_lit[i]);
                    cmp($sformatf("b.first_pass_wr[%0d]", i),   seq_wr[1][i],   b_wr_lit[i]);
                end
            end
        end
        pass_no[id]++;
    endtask

    // Move the model to the state the upcoming clock edge must produce.
    task automatic advanceModel(input int id);
        int cur_base;
        cur_base = (id == 0) ? int'(base_a) : int'(base_b);
        if (reset) begin
            m_phase[id] = 0;
            m_k[id]     = 0;
            m_base[id]  = 0;
            wr_cnt[id]  = 0;
        end else if (m_phase[id] != 1 && start) begin
            m_phase[id] = 1;
            m_k[id]     = 0;
`ifdef POOL_WR_BASE_EN
            m_base[id]  = cur_base;
`else
            m_base[id]  = 0;
            if (cur_base < 0) m_base[id] = 0;
`endif
            wr_cnt[id]  = 0;
        end else if (m_phase[id] == 1 && enable) begin
            if (act_wr[id] != 0 && wr_cnt[id] < 16) begin
                seq_addr[id][wr_cnt[id]] = act_addr[id];
                seq_wr[id][wr_cnt[id]]   = act_wr[id];
            end
            if (act_wr[id] != 0) wr_cnt[id]++;
            m_k[id]++;
            if (m_k[id] == mw[id] * mh[id] * mc[id]) begin
                m_phase[id] = 2;
                m_k[id]     = 0;
                checkPass(id);
            end
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        act_wr[0]   = int'(bus_a.wr_en);
        act_addr[0] = int'(bus_a.addr);
        act_ch[0]   = int'(bus_a.ch);
        act_busy[0] = int'(bus_a.busy);
        act_done[0] = int'(bus_a.done);
        act_wr[1]   = int'(bus_b.wr_en);
        act_addr[1] = int'(bus_b.addr);
        act_ch[1]   = int'(bus_b.ch);
        act_busy[1] = int'(bus_b.busy);
        act_done[1] = int'(bus_b.done);
        for (int id = 0; id < 2; id++) begin
            checkOutput(id);
            advanceModel(id);
        end
    end

    task automatic applyStimulus(input logic s, input logic e, input logic r);
        start  = s;
        enable = e;
        reset  = r;
        @(posedge clk);
        #1;
    endtask

    // mode 0: enable held high; 1: enable pattern 1,0,0; 2: random enable.
    // A start pulse at cycle 3 lands mid-pass and must be ignored.
    task automatic runUntilDone(input int mode);
        int i;
        logic e;
        i = 0;
        while (!(bus_a.done && bus_b.done) && i < 400) begin
            case (mode)
                0:       e = 1'b1;
                1:       e = ((i % 3) == 0);
                default: e = 1'($urandom_range(0, 1));
            endcase
            applyStimulus(i == 3, e, 1'b0);
            i++;
        end
        checks++;
        if (!(bus_a.done && bus_b.done)) begin
            failures++;
            $display("[TB] FAIL pass_timeout: done_a=%0b done_b=%0b, expected both 1", bus_a.done, bus_b.done);
        end
    endtask

    initial begin
        start  = 1'b0;
        enable = 1'b0;
        reset  = 1'b1;
        base_a = A_AW'(A_BASE0);
        base_b = '0;

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        runUntilDone(0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        base_a = A_AW'($urandom);
        base_b = B_AW'($urandom);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runUntilDone(1);

        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runUntilDone(2);

        for (int p = 0; p < 3; p++) begin
            base_a = A_AW'($urandom);
            base_b = B_AW'($urandom);
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            runUntilDone(2);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_mem_write_ctrl.md
# pool_mem_write_ctrl

Parametrised write-address generator for pooling-layer output memories. It replaces the per-layer fixed 4-bit write counters with one block covering any image size and channel count. It accepts a start pulse, issues one memory write per enabled cycle in channel-innermost, column, then row order, and raises a sticky `done` after the last write. It sits between a pooling unit's output-valid strobe and the bank of per-channel output RAMs.

## Interface
Parameters:
- `IMG_W`, default 4: output feature-map width in pixels, ≥1.
- `IMG_H`, default 4: output feature-map height in pixels, ≥1.
- `CHANNELS`, default 1: number of output RAMs (one per feature channel), ≥1.
- `ADDR_W`, default `$clog2(IMG_W*IMG_H)` (minimum 1): RAM address width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `start`, input, 1: begin a new pass; sampled in IDLE or DONE only.
- `enable`, input, 1: pooling result valid this cycle; one write is issued per enabled cycle in WRITE.
- `wr_en`, output, `CHANNELS`: one-hot write strobe to the channel RAM addressed this cycle.
- `addr`, output, `ADDR_W`: pixel address, row*IMG_W + col, shared by all RAMs.
- `ch`, output, `$clog2(CHANNELS)` (minimum 1): current channel index.
- `busy`, output, 1: high in WRITE.
- `done`, output, 1: sticky pass-complete flag.

## Operation
- States: IDLE, WRITE, DONE (held in a 2-bit enum).
- IDLE → WRITE on `start`. `ch`, col, row and `addr` are cleared on the same edge.
- WRITE: while `enable`=1, `wr_en[ch]`=1 and the other bits are 0; the counters advance at the clock edge.
  - `ch` counts 0..CHANNELS-1, then wraps to 0 and increments col.
  - col counts 0..IMG_W-1, then wraps to 0 and increments row.
  - `addr` increments by 1 on each col or row step and never recomputes with a multiply.
- If `enable`=0 in WRITE, `wr_en`=0 and the counters hold. Stalls of any length are legal.
- On the enabled write with ch=CHANNELS-1, col=IMG_W-1, row=IMG_H-1, the next state is DONE and the counters wrap to 0.
- DONE: `done`=1, `wr_en`=0, and `enable` is ignored. `start` clears `done` and re-enters WRITE with the counters at 0.
- `start` during WRITE is ignored; the pass is not restarted.
- `enable` in IDLE or DONE is ignored; no write is issued.
- If `start` and `enable` are both high in IDLE, only `start` takes effect. The first write occurs on the next enabled cycle.
- `reset` at any time, including mid-pass, forces IDLE with every counter at 0 and `done`=0. No partial-pass state is retained.
- Total writes per pass are exactly IMG_W*IMG_H*CHANNELS.

## Timing
- Reset values: `wr_en`=0, `addr`=0, `ch`=0, `busy`=0, `done`=0.
- `addr`, `ch`, `busy` and `done` are registered.
- `wr_en` is combinational: `enable` AND (state==WRITE), decoded with `ch`. It is aligned with the current `addr`/`ch` in the same cycle.
- Latency:
  - The `start` edge puts the block in WRITE on the next cycle (`busy`=1).
  - `done` rises on the edge that retires the final write. It is visible in the cycle after the last `wr_en`.
- Minimum pass length is IMG_W*IMG_H*CHANNELS + 1 cycles from `start` to `done`.

## Configuration
- `POOL_WR_BASE_EN`:
  - When defined, the block adds input `base_addr` [ADDR_W-1:0], latched on the accepted `start`.
  - The emitted `addr` is then base + pixel index, computed modulo 2^ADDR_W. Several maps can then be packed in one RAM, provided the user sizes ADDR_W for it.
- When undefined, there is no `base_addr` port and `addr` equals the pixel index.

## Structure
- Package `pool_mem_pkg` holds:
  - the state enum type `wr_state_t` (IDLE, WRITE, DONE);
  - helper function `clog2_min1` for the `ch`/`addr` width derivation.
- Sub-module `wrap_counter` (parameter `N`; inputs `clk`, `reset`, `clr`, `inc`; outputs `cnt`, `last`) is instantiated three times, for ch, col and row.
  - The row instance's `last` gated with the col and ch `last` outputs forms the terminal condition.

## Test plan
- Default 4×4×1, `start` then `enable` held high: 16 writes, `addr` 0..15, `wr_en`=1 each cycle, `done`=1 in the cycle after `addr`=15 and held.
- IMG_W=3, IMG_H=2, CHANNELS=2, `enable` high: `wr_en` alternates 01/10 per `addr`; `addr` sequence is 0,0,1,1,…,5,5; 12 writes, then `done`.
- 4×4×1 with `enable` toggling 1,0,0,1…: `addr` holds during gaps, no write while `enable`=0, still exactly 16 writes.
- Assert `reset` after write 7, then `start`: all outputs are 0 after reset; the next pass starts at `addr`=0 with `done`=0.
- `start` pulsed mid-pass and `enable` high in DONE: pass not restarted, no extra `wr_en`. A later `start` in DONE clears `done` and repeats the 16-write sequence.
- `POOL_WR_BASE_EN` defined, ADDR_W=6, `base_addr`=32: `addr` runs 32..47, then `done`.
